// File: rtl/barrel_scheduler.sv
// barrel_scheduler: owns NUM_BARRELS rolling barrels, spawns and moves them once per frame, maps pixels to sprite offsets.
// Latency: pixel lookup is 1 cycle registered; a frame update takes NUM_BARRELS+1 cycles after an accepted frame_tick.
// Backpressure: none; frame_tick arriving while busy or disabled is dropped, pixel lookup never stalls.
module barrel_scheduler #(
  parameter int NUM_BARRELS  = 4,
  parameter int SPEED        = 2,
  parameter int SPAWN_PERIOD = 60,
  parameter int SPAWN_X      = 32,
  parameter int SPAWN_Y      = 40,
  parameter int X_MIN        = 16,
  parameter int X_MAX        = 608,
  parameter int FALL_DIST    = 48,
  parameter int Y_BOTTOM     = 464
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   enable,
  input  logic [9:0]             hcount,
  input  logic [9:0]             vcount,
  output logic [9:0]             spr_horz,
  output logic [9:0]             spr_vert,
  output logic                   barrel_hit,
  output logic [NUM_BARRELS-1:0] active_mask,
  output logic                   busy,
  output logic                   spawn_pulse
);

  localparam int IDX_W = (NUM_BARRELS > 1) ? $clog2(NUM_BARRELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BARRELS - 1);
  localparam logic [9:0]       SPEED_V    = 10'(SPEED);
  localparam logic [9:0]       X_MIN_V    = 10'(X_MIN);
  localparam logic [9:0]       X_MAX_V    = 10'(X_MAX);
  localparam logic [9:0]       FALL_V     = 10'(FALL_DIST);
  localparam logic [9:0]       Y_BOTTOM_V = 10'(Y_BOTTOM);
  localparam logic [15:0]      SPAWN_LAST = 16'(SPAWN_PERIOD - 1);

  typedef enum logic [1:0] {SLOT_FREE, SLOT_ROLL_R, SLOT_ROLL_L, SLOT_FALL} slot_state_t;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_UPDATE, SEQ_SPAWN} seq_state_t;

  typedef struct packed {
    slot_state_t state;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  fall_cnt;
  } slot_t;

  localparam slot_t SPAWN_SLOT = '{state: SLOT_ROLL_R, x: 10'(SPAWN_X), y: 10'(SPAWN_Y), fall_cnt: 10'd0};

  slot_t            slot [NUM_BARRELS];
  seq_state_t       seq;
  logic [IDX_W-1:0] idx;
  logic [15:0]      spawn_cnt;
  slot_t            cur;
  slot_t            nxt;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [9:0]       dx [NUM_BARRELS];
  logic [9:0]       dy [NUM_BARRELS];
  logic             hit_c;
  logic [3:0]       dx_c;
  logic [3:0]       dy_c;

  assign busy = (seq != SEQ_IDLE);

  // Next state of the slot addressed by idx: one move step, then free it if it dropped off the bottom
  always_comb begin
    cur = slot[idx];
    nxt = cur;
    case (cur.state)
      SLOT_ROLL_R: begin
        if (cur.x + SPEED_V >= X_MAX_V) begin
          nxt.x        = X_MAX_V;
          nxt.state    = SLOT_FALL;
          nxt.fall_cnt = '0;
        end else begin
          nxt.x = cur.x + SPEED_V;
        end
      end
      SLOT_ROLL_L: begin
        if (cur.x <= X_MIN_V + SPEED_V) begin
          nxt.x        = X_MIN_V;
          nxt.state    = SLOT_FALL;
          nxt.fall_cnt = '0;
        end else begin
          nxt.x = cur.x - SPEED_V;
        end
      end
      SLOT_FALL: begin
        nxt.y        = cur.y + SPEED_V;
        nxt.fall_cnt = cur.fall_cnt + SPEED_V;
        if (cur.fall_cnt + SPEED_V >= FALL_V) begin
          nxt.state    = (cur.x == X_MAX_V) ? SLOT_ROLL_L : SLOT_ROLL_R;
          nxt.fall_cnt = '0;
        end
      end
      default: ;
    endcase
    if (cur.state != SLOT_FREE && nxt.y >= Y_BOTTOM_V) nxt.state = SLOT_FREE;
  end

  // Lowest-index free slot receives the next spawn
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_BARRELS - 1; i >= 0; i--) begin
      if (slot[i].state == SLOT_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Occupancy view of all slots
  always_comb begin
    active_mask = '0;
    for (int i = 0; i < NUM_BARRELS; i++) active_mask[i] = (slot[i].state != SLOT_FREE);
  end

  // Pixel-to-barrel match; scanning high to low lets slot 0 win overlaps
  always_comb begin
    hit_c = 1'b0;
    dx_c  = '0;
    dy_c  = '0;
    for (int i = NUM_BARRELS - 1; i >= 0; i--) begin
      dx[i] = hcount - slot[i].x;
      dy[i] = vcount - slot[i].y;
      if (slot[i].state != SLOT_FREE && dx[i] < 10'd16 && dy[i] < 10'd16) begin
        hit_c = 1'b1;
        dx_c  = dx[i][3:0];
        dy_c  = dy[i][3:0];
      end
    end
  end

  // Register the lookup result for the sprite ROM address
  always_ff @(posedge clk) begin
    if (rst) begin
      barrel_hit <= 1'b0;
      spr_horz   <= '0;
      spr_vert   <= '0;
    end else begin
      barrel_hit <= hit_c;
      spr_horz   <= {6'b0, dx_c};
      spr_vert   <= {6'b0, dy_c};
    end
  end

  // Frame sequencer: walk every slot once, then one spawn decision, then back to idle
  always_ff @(posedge clk) begin
    if (rst) begin
      seq         <= SEQ_IDLE;
      idx         <= '0;
      spawn_cnt   <= '0;
      spawn_pulse <= 1'b0;
      for (int i = 0; i < NUM_BARRELS; i++) slot[i] <= '0;
    end else begin
      spawn_pulse <= 1'b0;
      case (seq)
        SEQ_IDLE: begin
          if (frame_tick && enable) begin
            seq <= SEQ_UPDATE;
            idx <= '0;
          end
        end
        SEQ_UPDATE: begin
          slot[idx] <= nxt;
          if (idx == LAST_IDX) seq <= SEQ_SPAWN;
          else                 idx <= idx + 1'b1;
        end
        SEQ_SPAWN: begin
          seq <= SEQ_IDLE;
          if (spawn_cnt == SPAWN_LAST) begin
            spawn_cnt <= '0;
            if (free_found) begin
              slot[free_idx] <= SPAWN_SLOT;
              spawn_pulse    <= 1'b1;
            end
          end else begin
            spawn_cnt <= spawn_cnt + 16'd1;
          end
        end
        default: seq <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_scheduler.sv
// tb_barrel_scheduler: randomized frame/probe stimulus against a per-frame barrel model, two instances sharing inputs.
// Latency: lookups expected one cycle after the pixel is driven; spawn pulses expected after the frame they belong to.
// Backpressure: none; ticks during busy or with enable low are expected to be dropped.
module tb_barrel_scheduler;
  localparam int NB        = 4;
  localparam int SPEED     = 2;
  localparam int SPAWN_X   = 32;
  localparam int SPAWN_Y   = 40;
  localparam int X_MIN     = 16;
  localparam int X_MAX     = 608;
  localparam int FALL_DIST = 48;
  localparam int Y_BOTTOM  = 464;
  localparam int PERIOD_A  = 60;
  localparam int PERIOD_B  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, frame_tick, enable, probe_vld;
  logic [9:0]    hcount, vcount;
  logic [9:0]    horz_a, vert_a, horz_b, vert_b;
  logic          hit_a, hit_b, busy_a, busy_b, sp_a, sp_b;
  logic [NB-1:0] mask_a, mask_b;

  barrel_scheduler dut_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .hcount(hcount), .vcount(vcount), .spr_horz(horz_a), .spr_vert(vert_a),
    .barrel_hit(hit_a), .active_mask(mask_a), .busy(busy_a), .spawn_pulse(sp_a)
  );

  barrel_scheduler #(.SPAWN_PERIOD(PERIOD_B)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .hcount(hcount), .vcount(vcount), .spr_horz(horz_b), .spr_vert(vert_b),
    .barrel_hit(hit_b), .active_mask(mask_b), .busy(busy_b), .spawn_pulse(sp_b)
  );

  // ---------------- reference model: barrels as position + direction + falling flag
  bit m_alive   [2][NB];
  bit m_falling [2][NB];
  int m_x       [2][NB];
  int m_y       [2][NB];
  int m_fallen  [2][NB];
  int m_dir     [2][NB];
  int m_cnt     [2];

  int spq_a[$];
  int spq_b[$];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      for (int s = 0; s < NB; s++) begin
        m_alive[k][s] = 0; m_falling[k][s] = 0;
        m_x[k][s] = 0; m_y[k][s] = 0; m_fallen[k][s] = 0; m_dir[k][s] = 1;
      end
    end
  endfunction

  function automatic int model_mask(input int k);
    int m = 0;
    for (int s = 0; s < NB; s++) if (m_alive[k][s]) m |= (1 << s);
    return m;
  endfunction

  function automatic void model_frame(input int k);
    int period = (k == 0) ? PERIOD_A : PERIOD_B;
    bit placed = 0;
    for (int s = 0; s < NB; s++) begin
      if (m_alive[k][s]) begin
        if (m_falling[k][s]) begin
          m_y[k][s] += SPEED;
          m_fallen[k][s] += SPEED;
          if (m_fallen[k][s] >= FALL_DIST) begin
            m_falling[k][s] = 0;
            m_fallen[k][s] = 0;
            m_dir[k][s] = (m_x[k][s] == X_MAX) ? -1 : 1;
          end
        end else begin
          m_x[k][s] += m_dir[k][s] * SPEED;
          if ((m_dir[k][s] > 0 && m_x[k][s] >= X_MAX) || (m_dir[k][s] < 0 && m_x[k][s] <= X_MIN)) begin
            m_x[k][s] = (m_dir[k][s] > 0) ? X_MAX : X_MIN;
            m_falling[k][s] = 1;
            m_fallen[k][s] = 0;
          end
        end
        if (m_y[k][s] >= Y_BOTTOM) m_alive[k][s] = 0;
      end
    end
    if (m_cnt[k] == period - 1) begin
      m_cnt[k] = 0;
      for (int s = 0; s < NB; s++) begin
        if (!placed && !m_alive[k][s]) begin
          placed = 1;
          m_alive[k][s] = 1; m_falling[k][s] = 0; m_dir[k][s] = 1;
          m_x[k][s] = SPAWN_X; m_y[k][s] = SPAWN_Y; m_fallen[k][s] = 0;
        end
      end
      if (placed) begin
        if (k == 0) spq_a.push_back(model_mask(0));
        else        spq_b.push_back(model_mask(1));
      end
    end else begin
      m_cnt[k] += 1;
    end
  endfunction

  function automatic void model_lookup(input int k, input int h, input int v,
                                       output int hit, output int ox, output int oy);
    hit = 0; ox = 0; oy = 0;
    for (int s = NB - 1; s >= 0; s--) begin
      int ddx = (h - m_x[k][s]) & 1023;
      int ddy = (v - m_y[k][s]) & 1023;
      if (m_alive[k][s] && ddx < 16 && ddy < 16) begin
        hit = 1; ox = ddx; oy = ddy;
      end
    end
  endfunction

  // ---------------- scoreboard
  typedef struct {
    string name;
    int    hit_a, ha, va, hit_b, hb, vb;
  } look_t;

  typedef struct {
    string name;
    bit    use_busy;
    int    busy;
    bit    use_mask;
    int    ma, mb;
    bit    use_out;
    bit    use_end;
  } stat_t;

  look_t lq[$];
  stat_t sq[$];
  int    checks = 0;
  int    failures = 0;
  logic  pend = 1'b0;

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  always @(posedge clk) pend <= probe_vld;

  // monitor: lookups one cycle after the probe, status items in the cycle they were issued, spawn pulses as they occur
  always @(negedge clk) begin
    look_t li;
    stat_t si;
    if (pend === 1'b1) begin
      if (lq.size() == 0) cmp("lookup_unexpected", 1, 0);
      else begin
        li = lq.pop_front();
        cmp({li.name, "_hit_a"},  int'(hit_a),  li.hit_a);
        cmp({li.name, "_horz_a"}, int'(horz_a), li.ha);
        cmp({li.name, "_vert_a"}, int'(vert_a), li.va);
        cmp({li.name, "_hit_b"},  int'(hit_b),  li.hit_b);
        cmp({li.name, "_horz_b"}, int'(horz_b), li.hb);
        cmp({li.name, "_vert_b"}, int'(vert_b), li.vb);
      end
    end
    while (sq.size() > 0) begin
      si = sq.pop_front();
      if (si.use_busy) begin
        cmp({si.name, "_busy_a"}, int'(busy_a), si.busy);
        cmp({si.name, "_busy_b"}, int'(busy_b), si.busy);
      end
      if (si.use_mask) begin
        cmp({si.name, "_mask_a"}, int'(mask_a), si.ma);
        cmp({si.name, "_mask_b"}, int'(mask_b), si.mb);
      end
      if (si.use_out) begin
        cmp({si.name, "_hit_a"}, int'(hit_a), 0);
        cmp({si.name, "_spr_a"}, int'({horz_a, vert_a}), 0);
        cmp({si.name, "_hit_b"}, int'(hit_b), 0);
        cmp({si.name, "_spr_b"}, int'({horz_b, vert_b}), 0);
        cmp({si.name, "_spawn"}, int'({sp_a, sp_b}), 0);
      end
      if (si.use_end) begin
        cmp("leftover_lookups", lq.size(), 0);
        cmp("missing_spawn_a", spq_a.size(), 0);
        cmp("missing_spawn_b", spq_b.size(), 0);
      end
    end
    if (sp_a === 1'b1) begin
      if (spq_a.size() == 0) cmp("spawn_a_unexpected", 1, 0);
      else cmp("spawn_a_mask", int'(mask_a), spq_a.pop_front());
    end
    if (sp_b === 1'b1) begin
      if (spq_b.size() == 0) cmp("spawn_b_unexpected", 1, 0);
      else cmp("spawn_b_mask", int'(mask_b), spq_b.pop_front());
    end
  end

  // ---------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stat(input string name, input bit ub, input int b, input bit um,
                           input int ma, input int mb, input bit uo, input bit ue);
    stat_t s;
    s.name = name; s.use_busy = ub; s.busy = b; s.use_mask = um;
    s.ma = ma; s.mb = mb; s.use_out = uo; s.use_end = ue;
    sq.push_back(s);
  endtask

  task automatic probe(input int h, input int v, input bit use_const,
                       input int ch, input int cx, input int cy);
    look_t li;
    int mh, mx, my;
    hcount = 10'(h);
    vcount = 10'(v);
    probe_vld = 1'b1;
    li.name = $sformatf("lookup(%0d,%0d)", h, v);
    model_lookup(0, h, v, mh, mx, my);
    if (use_const) begin
      li.hit_a = ch; li.ha = cx; li.va = cy;
    end else begin
      li.hit_a = mh; li.ha = mx; li.va = my;
    end
    model_lookup(1, h, v, mh, mx, my);
    li.hit_b = mh; li.hb = mx; li.vb = my;
    lq.push_back(li);
    step();
    probe_vld = 1'b0;
  endtask

  task automatic rand_probe();
    int k = int'($urandom_range(1, 0));
    int s = int'($urandom_range(NB - 1, 0));
    int ox = int'($urandom_range(21, 0)) - 3;
    int oy = int'($urandom_range(21, 0)) - 3;
    if (m_alive[k][s]) probe((m_x[k][s] + ox) & 1023, (m_y[k][s] + oy) & 1023, 0, 0, 0, 0);
    else               probe(int'($urandom_range(639, 0)), int'($urandom_range(479, 0)), 0, 0, 0, 0);
  endtask

  task automatic do_frame(input bit extra);
    int xpos = int'($urandom_range(NB + 1, 1));
    frame_tick = 1'b1;
    enable     = 1'b1;
    model_frame(0);
    model_frame(1);
    for (int c = 1; c <= NB + 2; c++) begin
      step();
      if (c == 1) push_stat("tick_accepted", 1, 1, 0, 0, 0, 0, 0);
      frame_tick = (extra && c == xpos);
    end
    push_stat("frame_done", 1, 0, 1, model_mask(0), model_mask(1), 0, 0);
  endtask

  task automatic dead_tick();
    frame_tick = 1'b1;
    enable     = 1'b0;
    step();
    frame_tick = 1'b0;
    enable     = 1'b1;
    push_stat("disabled_tick", 1, 0, 1, model_mask(0), model_mask(1), 0, 0);
    step();
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; enable = 1'b1;
    hcount = '0; vcount = '0; probe_vld = 1'b0;
    model_reset();
    step();
    step();
    push_stat("reset", 1, 0, 1, 0, 0, 1, 0);
    rst = 1'b0;
    step();

    for (int p = 1; p <= 3000; p++) begin
      if (p == 100) repeat (5) dead_tick();
      else if ($urandom_range(19, 0) == 0) dead_tick();
      do_frame($urandom_range(7, 0) == 0);
      if (p == 60) begin
        push_stat("first_spawn", 0, 0, 1, 1, model_mask(1), 0, 0);
        probe(32, 40, 1, 1, 0, 0);
      end
      if (p == 61) begin
        probe(42, 45, 1, 1, 8, 5);
        probe(50, 45, 1, 0, 0, 0);
      end
      if (p == 300) push_stat("all_slots_full", 0, 0, 1, 15, model_mask(1), 0, 0);
      if (p == 348) probe(608, 40, 1, 1, 0, 0);
      if (p == 372) probe(611, 95, 1, 1, 3, 7);
      if (p == 373) probe(606, 88, 1, 1, 0, 0);
      rand_probe();
      rand_probe();
    end

    // reset while the sequencer is on slot 2
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    push_stat("reset_mid_update", 1, 0, 1, 0, 0, 1, 0);
    step();

    for (int p = 1; p <= 65; p++) begin
      do_frame(1'b0);
      rand_probe();
    end

    step();
    step();
    push_stat("end", 0, 0, 0, 0, 0, 0, 1);
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
